// File: rtl/ir_line_tracker.sv
// rtl/ir_line_tracker.sv - debounced five-sensor IR line position tracker
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   en               tracking enable; low forces IDLE
//   L, LC, C, RC, R  raw infrared sensor bits
//   sensors_db[4:0]  debounced line bits {L,LC,C,RC,R}, 1 = line seen
//   pos[3:0]         signed line position, -4 (far left) .. +4 (far right)
//   state[1:0]       00 IDLE, 01 TRACK, 10 CROSS, 11 LOST
//   pos_valid        one-cycle strobe on the first cycle pos or state changes
module ir_line_tracker #(
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter int   LOST_TIMEOUT    = 50000,
    parameter logic SENSOR_ACTIVE   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              L,
    input  logic              LC,
    input  logic              C,
    input  logic              RC,
    input  logic              R,
    output logic [4:0]        sensors_db,
    output logic signed [3:0] pos,
    output logic [1:0]        state,
    output logic              pos_valid
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = (LOST_TIMEOUT < 2) ? 1 : $clog2(LOST_TIMEOUT + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(LOST_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        CROSS = 2'b10,
        LOST  = 2'b11
    } state_t;

    // Synchroniser and normalisation
    logic [4:0] raw_in;
    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] line_now;

    assign raw_in = {L, LC, C, RC, R};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            line_now[i] = (sync2[i] == SENSOR_ACTIVE);
        end
    end

    // Per-bit debounce: the flip happens on the edge where the count would
    // reach DEBOUNCE_CYCLES, so the counter itself never exceeds DB_LAST.
    logic [CW-1:0] db_cnt [5];

    for (genvar g = 0; g < 5; g++) begin : g_db
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt[g]     <= '0;
                sensors_db[g] <= 1'b0;
            end else if (line_now[g] == sensors_db[g]) begin
                db_cnt[g] <= '0;
            end else if (db_cnt[g] == DB_LAST) begin
                db_cnt[g]     <= '0;
                sensors_db[g] <= ~sensors_db[g];
            end else begin
                db_cnt[g] <= db_cnt[g] + 1'b1;
            end
        end
    end

    // Position encoding: weighted sum divided by count, truncated toward zero.
    logic [2:0]        n;
    logic signed [4:0] s;
    logic [4:0]        mag;
    logic [4:0]        quo;
    logic signed [3:0] raw_pos;
    logic signed [1:0] raw_side;

    always_comb begin
        n = 3'(sensors_db[4]) + 3'(sensors_db[3]) + 3'(sensors_db[2])
          + 3'(sensors_db[1]) + 3'(sensors_db[0]);
        s = 5'sd0;
        if (sensors_db[4]) s = s - 5'sd4;
        if (sensors_db[3]) s = s - 5'sd2;
        if (sensors_db[1]) s = s + 5'sd2;
        if (sensors_db[0]) s = s + 5'sd4;
        mag = s[4] ? 5'(-s) : 5'(s);
        quo = (n == 3'd0) ? 5'd0 : (mag / {2'b00, n});
        raw_pos = s[4] ? -$signed(quo[3:0]) : $signed(quo[3:0]);
        if (raw_pos < 0)      raw_side = -2'sd1;
        else if (raw_pos > 0) raw_side = 2'sd1;
        else                  raw_side = 2'sd0;
    end

    // Tracking FSM
    state_t            cur;
    state_t            nxt;
    logic signed [3:0] pos_n;
    logic signed [1:0] last_side;
    logic signed [1:0] side_n;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_n;
    logic signed [3:0] recover_pos;

    always_comb begin
        if (last_side < 0)      recover_pos = -4'sd4;
        else if (last_side > 0) recover_pos = 4'sd4;
        else                    recover_pos = 4'sd0;
    end

    always_comb begin
        nxt     = cur;
        pos_n   = pos;
        side_n  = last_side;
        timer_n = '0;
        if (!en) begin
            nxt   = IDLE;
            pos_n = 4'sd0;
        end else begin
            case (cur)
                IDLE: begin
                    nxt   = TRACK;
                    pos_n = 4'sd0;
                end
                TRACK: begin
                    if (n == 3'd0) begin
                        if (timer == TO_LAST) begin
                            nxt   = LOST;
                            pos_n = recover_pos;
                        end else begin
                            timer_n = timer + 1'b1;
                        end
                    end else if (n >= 3'd4) begin
                        nxt   = CROSS;
                        pos_n = 4'sd0;
                    end else begin
                        pos_n  = raw_pos;
                        side_n = raw_side;
                    end
                end
                CROSS: begin
                    pos_n = 4'sd0;
                    if (n <= 3'd2) begin
                        nxt = TRACK;
                        if (n != 3'd0) begin
                            pos_n  = raw_pos;
                            side_n = raw_side;
                        end
                    end
                end
                LOST: begin
                    pos_n = recover_pos;
                    if (n != 3'd0) begin
                        nxt   = TRACK;
                        pos_n = raw_pos;
                        if (n <= 3'd3) side_n = raw_side;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= IDLE;
            pos       <= 4'sd0;
            last_side <= 2'sd0;
            timer     <= '0;
            pos_valid <= 1'b0;
        end else begin
            cur       <= nxt;
            pos       <= pos_n;
            last_side <= side_n;
            timer     <= timer_n;
            pos_valid <= (pos_n != pos) || (nxt != cur);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_ir_line_tracker.sv
// tb/tb_ir_line_tracker.sv - scoreboard bench for ir_line_tracker
module tb_ir_line_tracker;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              L, LC, C, RC, R;
    logic [4:0]        sensors_db;
    logic signed [3:0] pos;
    logic [1:0]        state;
    logic              pos_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]        st;
        logic signed [3:0] p;
        logic [4:0]        sdb;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [1:0] S_IDLE = 2'b00, S_TRACK = 2'b01, S_CROSS = 2'b10, S_LOST = 2'b11;

    ir_line_tracker #(
        .DEBOUNCE_CYCLES(4),
        .LOST_TIMEOUT(10),
        .SENSOR_ACTIVE(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .L(L),
        .LC(LC),
        .C(C),
        .RC(RC),
        .R(R),
        .sensors_db(sensors_db),
        .pos(pos),
        .state(state),
        .pos_valid(pos_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [1:0] st, input int p, input logic [4:0] sdb);
        exp_t e;
        e.st  = st;
        e.p   = 4'(p);
        e.sdb = sdb;
        exp_q.push_back(e);
    endtask

    task automatic set_sensors(input logic [4:0] v);
        {L, LC, C, RC, R} = v;
    endtask

    // Monitor: every pos_valid strobe must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && pos_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pos_valid state=%b pos=%0d sdb=%b at %0t",
                         state, pos, sensors_db, $time);
            end else begin
                e = exp_q.pop_front();
                if (state !== e.st || pos !== e.p || sensors_db !== e.sdb) begin
                    errors++;
                    $display("FAIL event actual state=%b pos=%0d sdb=%b expected state=%b pos=%0d sdb=%b at %0t",
                             state, pos, sensors_db, e.st, e.p, e.sdb, $time);
                end
            end
        end
    end

    initial begin
        en = 1'b1;
        set_sensors(5'b00000);
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        tick(2);
        chk("reset_sdb", int'(sensors_db), 0);
        chk("reset_pos", int'(pos), 0);
        chk("reset_state", int'(state), int'(S_IDLE));
        chk("reset_valid", int'(pos_valid), 0);

        // C from reset release: IDLE->TRACK strobe, sensors_db after 6 edges
        push(S_TRACK, 0, 5'b00000);
        rst_n = 1'b1;
        C = 1'b1;
        tick(5);
        chk("c_db_edge5", int'(sensors_db), 0);
        tick(1);
        chk("c_db_edge6", int'(sensors_db), 5'b00100);
        tick(3);

        // 3-cycle glitch on R is discarded
        R = 1'b1;
        tick(3);
        R = 1'b0;
        tick(10);
        chk("glitch_sdb", int'(sensors_db), 5'b00100);

        // held R appears after 6 edges; C+R -> +2
        push(S_TRACK, 2, 5'b00101);
        R = 1'b1;
        tick(5);
        chk("r_db_edge5", int'(sensors_db), 5'b00100);
        tick(1);
        chk("r_db_edge6", int'(sensors_db), 5'b00101);
        tick(3);

        push(S_TRACK, -1, 5'b01100);
        set_sensors(5'b01100);
        tick(10);
        chk("lc_c_pos", int'(pos), -1);

        push(S_TRACK, 2, 5'b00010);
        set_sensors(5'b00010);
        tick(10);

        // line lost after 10 empty cycles, recovery steers right
        push(S_LOST, 4, 5'b00000);
        set_sensors(5'b00000);
        tick(6);
        chk("lost_sdb", int'(sensors_db), 0);
        tick(9);
        chk("lost_wait_state", int'(state), int'(S_TRACK));
        chk("lost_wait_pos", int'(pos), 2);
        tick(1);
        chk("lost_state", int'(state), int'(S_LOST));
        chk("lost_pos", int'(pos), 4);

        push(S_TRACK, -4, 5'b10000);
        set_sensors(5'b10000);
        tick(7);
        chk("reacq_pos", int'(pos), -4);
        tick(2);

        // crossing and exit with C only (state-only change)
        push(S_CROSS, 0, 5'b11111);
        set_sensors(5'b11111);
        tick(10);
        push(S_TRACK, 0, 5'b00100);
        set_sensors(5'b00100);
        tick(10);

        // en low mid-CROSS forces IDLE next edge
        push(S_CROSS, 0, 5'b11111);
        set_sensors(5'b11111);
        tick(10);
        push(S_IDLE, 0, 5'b11111);
        en = 1'b0;
        tick(1);
        chk("en_low_state", int'(state), int'(S_IDLE));
        tick(3);
        push(S_TRACK, 0, 5'b11111);
        push(S_CROSS, 0, 5'b11111);
        en = 1'b1;
        tick(5);

        push(S_TRACK, 2, 5'b00010);
        set_sensors(5'b00010);
        tick(10);
        push(S_LOST, 4, 5'b00000);
        set_sensors(5'b00000);
        tick(20);
        chk("lost2_state", int'(state), int'(S_LOST));

        // asynchronous reset mid-LOST with a debounce count in progress
        C = 1'b1;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_sdb", int'(sensors_db), 0);
        chk("areset_pos", int'(pos), 0);
        chk("areset_state", int'(state), int'(S_IDLE));
        chk("areset_valid", int'(pos_valid), 0);
        @(negedge clk);
        push(S_TRACK, 0, 5'b00000);
        rst_n = 1'b1;
        tick(5);
        chk("rerun_db_edge5", int'(sensors_db), 0);
        tick(1);
        chk("rerun_db_edge6", int'(sensors_db), 5'b00100);
        tick(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_line_tracker.md
Name: ir_line_tracker

Overview:
- Consumes the five conditioned infrared line-sensor bits L, LC, C, RC, R and produces a debounced, signed line-position estimate plus tracking status for the motion controller.
- Synchronises and debounces each sensor, then encodes the line position.
- An FSM classifies the situation as idle, tracking, crossing/intersection or line lost, with a lost-line timeout and a last-side memory used for recovery steering.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive cycles a synchronised bit must differ from its debounced value before that value flips (>=1).
LOST_TIMEOUT, 50000, consecutive cycles with no sensor active in TRACK before entering LOST (>=1).
SENSOR_ACTIVE, 1, raw sensor level that means "line detected".

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  tracking enable
L, LC, C, RC, R  input  1 each  raw sensor bits from the infrared stage
sensors_db  output  5  debounced, normalised sensors {L,LC,C,RC,R}; 1 = line
pos  output  4  signed position, -4 (far left) .. +4 (far right)
state  output  2  00 IDLE, 01 TRACK, 10 CROSS, 11 LOST
pos_valid  output  1  one-cycle strobe when pos or state changes

Behaviour:
- Reset is asynchronous: all synchroniser flops, debounce counters, timer and registers clear; sensors_db=0, pos=0, state=IDLE, pos_valid=0. Asserting reset mid-operation aborts everything the same way.
- Synchroniser: each raw bit passes two flops (reset 0), then is normalised: line = (bit == SENSOR_ACTIVE).
- Debounce, per bit:
  - If the normalised bit equals sensors_db[i], the counter clears.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, sensors_db[i] flips and the counter clears.
  - A stable input change appears on sensors_db exactly 2+DEBOUNCE_CYCLES edges after the first edge that samples it.
  - A glitch shorter than DEBOUNCE_CYCLES is discarded.
- Encoding on sensors_db:
  - Weights: L=-4, LC=-2, C=0, RC=+2, R=+4.
  - n = number of active bits; s = sum of active weights.
  - raw = s/n, truncated toward zero, for n>=1. Examples: LC+C gives -1; C+RC+R gives +2.
- FSM (registered; en low forces IDLE from any state and takes priority over all other transitions):
  - IDLE: pos held at 0. When en=1, go to TRACK next cycle.
  - TRACK:
    - n in 1..3: pos=raw, last_side=sign(raw) (0 is kept as 0).
    - n>=4: go to CROSS; pos=0.
    - n==0: pos holds and lost timer increments. When the timer reaches LOST_TIMEOUT, go to LOST. Any n>=1 clears the timer.
  - CROSS: pos=0. When n<=2, return to TRACK with pos=raw (or hold pos if n==0, timer starting at 0).
  - LOST: pos = -4 if last_side<0, +4 if >0, else 0. When n>=1, go to TRACK with pos=raw and the timer cleared.
- TRACK-with-n==0 is the only place the timer counts; it clears on every other state and on entry to TRACK.
- pos_valid: high for exactly one cycle, the first cycle a new pos or state value is visible. It is not asserted when the values are unchanged. Simultaneous pos and state change gives a single pulse.
- pos and state update one edge after sensors_db changes.
- Width rules: debounce counter width = clog2(DEBOUNCE_CYCLES+1); timer width = clog2(LOST_TIMEOUT+1). Both saturate, never wrap. s fits in signed 5 bits.

Test Plan:
- DEBOUNCE_CYCLES=4, LOST_TIMEOUT=10, en=1. Assert C high from reset release -> sensors_db=00100 exactly 6 edges later; pos=0, state=TRACK; pos_valid pulses once on the state change.
- Pulse R high for 3 cycles -> sensors_db unchanged, no pos_valid. Hold R for 4+ cycles -> R bit set 6 edges after first sample.
- Steady LC+C (sensors_db=01100) -> pos=-1. Then only RC -> pos=+2 with one pos_valid each change.
- From pos=+2, drop all sensors -> pos holds +2 for 10 cycles, then state=LOST and pos=+4. Reassert L -> TRACK, pos=-4, timer cleared.
- All five active -> state=CROSS, pos=0. Reduce to C only -> TRACK, pos=0, single pos_valid. Drop en mid-CROSS -> IDLE next edge regardless of sensors.
- Assert rst_n low mid-LOST with counters nonzero -> all outputs 0 and state=IDLE immediately (asynchronous). After release, debounce restarts from zero and a held input needs the full 6 edges.
